pulse_train_detector: RTL and testbench
=======================================

Name: pulse_train_detector

Overview:
- Receive-side counterpart to the pulse generator.
- Samples a single-wire pulse train and measures every level segment between edges in clock cycles.
- Checks each segment against the nominal pulse width, counts flips and pulses, detects end-of-train by idle timeout, then reports count and start/end polarity.
- Sits on the GPIO/test-stimulus input path, feeding status registers.

Parameters:
- ClockPeriod, 50, clock period in ns.
- PulseWidth, 100, nominal width of one level segment in ns. NomCycles = PulseWidth/ClockPeriod + 1 clocks per segment.
- WidthTol, 1, allowed deviation in clocks. Accepted segment window is [NomCycles-WidthTol, NomCycles+WidthTol]; lower bound clamps at 1.
- TimeoutMul, 4, end-of-train timeout. TimeoutCycles = NomCycles*TimeoutMul.
- MaxPulseCnt, 15, largest reportable pulse count. Flip counter saturates at 2*MaxPulseCnt+1.
- SyncStages, 2, input synchronizer depth (≥2).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- arm_i  in  1  detector enable, level-sensitive.
- pulse_i  in  1  asynchronous pulse input.
- busy_o  out  1  high while a train is being measured.
- done_o  out  1  one-cycle strobe at end of train.
- pulse_cnt_o  out  $clog2(MaxPulseCnt+1)  completed pulses, equal to flip count >> 1.
- flip_cnt_o  out  $clog2(2*MaxPulseCnt+2)  edges seen in the train.
- start_pol_o  out  1  line level before the first edge.
- end_pol_o  out  1  line level at timeout.
- width_err_o  out  1  at least one bounded segment fell outside the window.
- overflow_o  out  1  flip counter saturated.

Behaviour:
- Reset (async, active-high): FSM→IDLE; all outputs 0; sync chain and counters cleared.
- Input path:
  - pulse_i passes through SyncStages FFs, then one history FF.
  - edge = sync_out ^ hist.
  - Edge-to-FSM latency is SyncStages+1 clocks; this latency is constant and never affects width measurement.
- FSM states: IDLE, WAIT_EDGE, MEASURE, DONE.
- IDLE:
  - Leave when arm_i=1 → WAIT_EDGE.
  - On entry to WAIT_EDGE, clear flip_cnt_o, width_err_o and overflow_o; pulse_cnt_o, start_pol_o and end_pol_o hold their previous values until the next first edge.
- WAIT_EDGE:
  - No timeout.
  - On the first edge: start_pol_o = hist; flip_cnt=1; seg_cnt=1; busy_o=1; → MEASURE.
- MEASURE: seg_cnt increments every cycle.
  - On an edge:
    - If seg_cnt is outside the window, set width_err_o (sticky until next train).
    - flip_cnt++ (saturate at 2*MaxPulseCnt+1; overflow_o=1 on any edge arriving while saturated).
    - seg_cnt=1.
  - On no edge with seg_cnt == TimeoutCycles: end_pol_o = sync_out; pulse_cnt_o = flip_cnt>>1; busy_o=0; → DONE.
  - The final (unbounded) segment is never width-checked.
- DONE:
  - done_o=1 for exactly one cycle.
  - Next state: WAIT_EDGE if arm_i=1, else IDLE.
  - An edge seen in DONE is treated as the first edge of a new train.
- arm_i deasserted in WAIT_EDGE or MEASURE:
  - Abort → IDLE next cycle, busy_o=0, no done_o.
  - Counters and flags keep their partial values; pulse_cnt_o is not updated.
- Edge on the same cycle as seg_cnt == TimeoutCycles: the edge wins; the segment is measured normally and there is no timeout.
- seg_cnt width is $clog2(TimeoutCycles+1); it never wraps because timeout occurs first.
- Pulse decoding: flips = 2*pulses + (start_pol ^ end_pol).
  - pulse_cnt_o is floor(flips/2).
  - end_pol_o ^ start_pol_o equals flip_cnt_o[0].
- Output hold: all outputs except done_o are registered and hold until the next first edge (or the WAIT_EDGE entry clear listed above), or until reset.

Test Plan:
1. Defaults (NomCycles=3, window [2,4], timeout 12); arm, then drive 0→1→0→1→0 with 3-clock segments, idle low. → done_o strobes exactly 12 clocks after the last synchronized edge; flip_cnt_o=4, pulse_cnt_o=2, start_pol_o=0, end_pol_o=0, width_err_o=0.
2. Start high, 5 edges of 3 clocks each, idle low. → flip_cnt_o=5, pulse_cnt_o=2, start_pol_o=1, end_pol_o=0.
3. 2-pulse train where one middle segment lasts 6 clocks. → width_err_o=1, pulse_cnt_o=2; a following clean train clears width_err_o to 0.
4. 40 edges at 3-clock spacing. → flip_cnt_o=31, pulse_cnt_o=15, overflow_o=1.
5. Drop arm_i after 2 edges. → busy_o=0 next clock, no done_o; re-arm and send a 1-pulse train → pulse_cnt_o=1.
6. Assert reset asynchronously mid-MEASURE (between clock edges). → all outputs 0 immediately; after release and arm, a 3-pulse train reports pulse_cnt_o=3.

Source files
------------

// File: rtl/pulse_train_detector.sv
// pulse_train_detector: samples an asynchronous single-wire pulse train,
// measures each level segment in clocks, flags out-of-window segments,
// counts edges and pulses, and reports polarity once the line goes idle.
module pulse_train_detector #(
  parameter int unsigned ClockPeriod = 50,
  parameter int unsigned PulseWidth  = 100,
  parameter int unsigned WidthTol    = 1,
  parameter int unsigned TimeoutMul  = 4,
  parameter int unsigned MaxPulseCnt = 15,
  parameter int unsigned SyncStages  = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   arm_i,
  input  logic                                   pulse_i,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic [$clog2(MaxPulseCnt+1)-1:0]       pulse_cnt_o,
  output logic [$clog2(2*MaxPulseCnt+2)-1:0]     flip_cnt_o,
  output logic                                   start_pol_o,
  output logic                                   end_pol_o,
  output logic                                   width_err_o,
  output logic                                   overflow_o
);

  localparam int unsigned NomCycles     = PulseWidth / ClockPeriod + 1;
  localparam int unsigned WinLo         = (NomCycles > WidthTol + 1) ? (NomCycles - WidthTol) : 1;
  localparam int unsigned WinHi         = NomCycles + WidthTol;
  localparam int unsigned TimeoutCycles = NomCycles * TimeoutMul;
  localparam int unsigned SegW          = $clog2(TimeoutCycles + 1);
  localparam int unsigned FlipW         = $clog2(2 * MaxPulseCnt + 2);
  localparam int unsigned PulseW        = $clog2(MaxPulseCnt + 1);
  localparam int unsigned FlipMax       = 2 * MaxPulseCnt + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_EDGE,
    MEASURE,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  hist_q, hist_d;
  logic [SegW-1:0]       seg_q, seg_d;
  logic [FlipW-1:0]      flip_q, flip_d;
  logic [PulseW-1:0]     pulse_q, pulse_d;
  logic                  start_pol_q, start_pol_d;
  logic                  end_pol_q, end_pol_d;
  logic                  werr_q, werr_d;
  logic                  ovf_q, ovf_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  sync_out_c;
  logic                  edge_c;
  logic                  first_edge_c;
  logic                  clear_c;

  assign sync_out_c = sync_q[SyncStages-1];
  assign edge_c     = sync_out_c ^ hist_q;

  // Next-state, counter and output computation.
  always_comb begin
    state_d      = state_q;
    sync_d       = {sync_q[SyncStages-2:0], pulse_i};
    hist_d       = sync_out_c;
    seg_d        = seg_q;
    flip_d       = flip_q;
    pulse_d      = pulse_q;
    start_pol_d  = start_pol_q;
    end_pol_d    = end_pol_q;
    werr_d       = werr_q;
    ovf_d        = ovf_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    first_edge_c = 1'b0;
    clear_c      = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (arm_i) begin
          state_d = WAIT_EDGE;
          clear_c = 1'b1;
        end
      end
      WAIT_EDGE: begin
        if (!arm_i) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (edge_c) begin
          first_edge_c = 1'b1;
        end
      end
      MEASURE: begin
        if (!arm_i) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (edge_c) begin
          // Closed segment: check against the acceptance window.
          if ((seg_q < SegW'(WinLo)) || (seg_q > SegW'(WinHi))) begin
            werr_d = 1'b1;
          end
          if (flip_q == FlipW'(FlipMax)) begin
            ovf_d = 1'b1;
          end else begin
            flip_d = flip_q + FlipW'(1);
          end
          seg_d = SegW'(1);
        end else if (seg_q == SegW'(TimeoutCycles)) begin
          // Line idle long enough: the train is over.
          end_pol_d = sync_out_c;
          pulse_d   = PulseW'(flip_q >> 1);
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          seg_d = seg_q + SegW'(1);
        end
      end
      DONE: begin
        if (!arm_i) begin
          state_d = IDLE;
        end else if (edge_c) begin
          first_edge_c = 1'b1;
        end else begin
          state_d = WAIT_EDGE;
          clear_c = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Fresh train bookkeeping on entry to WAIT_EDGE.
    if (clear_c) begin
      flip_d = '0;
      werr_d = 1'b0;
      ovf_d  = 1'b0;
    end

    // First edge of a train: capture start polarity and open the first segment.
    if (first_edge_c) begin
      start_pol_d = hist_q;
      flip_d      = FlipW'(1);
      seg_d       = SegW'(1);
      werr_d      = 1'b0;
      ovf_d       = 1'b0;
      busy_d      = 1'b1;
      state_d     = MEASURE;
    end
  end

  // State, synchronizer and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      hist_q      <= 1'b0;
      seg_q       <= '0;
      flip_q      <= '0;
      pulse_q     <= '0;
      start_pol_q <= 1'b0;
      end_pol_q   <= 1'b0;
      werr_q      <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      hist_q      <= hist_d;
      seg_q       <= seg_d;
      flip_q      <= flip_d;
      pulse_q     <= pulse_d;
      start_pol_q <= start_pol_d;
      end_pol_q   <= end_pol_d;
      werr_q      <= werr_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pulse_cnt_o = pulse_q;
  assign flip_cnt_o  = flip_q;
  assign start_pol_o = start_pol_q;
  assign end_pol_o   = end_pol_q;
  assign width_err_o = werr_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_pulse_train_detector.sv
// Bench for pulse_train_detector: drives edge sequences described as gap
// lists and compares the end-of-train report with a train-level model.
module tb_pulse_train_detector;

  localparam int SYNC = 2;
  localparam int TO   = 12;
  localparam int LO   = 2;
  localparam int HI   = 4;
  localparam int FMAX = 31;
  localparam int LAT  = SYNC + 1 + TO;

  logic       clk = 1'b0;
  logic       reset;
  logic       arm_i;
  logic       pulse_i;
  logic       busy_o;
  logic       done_o;
  logic [3:0] pulse_cnt_o;
  logic [4:0] flip_cnt_o;
  logic       start_pol_o;
  logic       end_pol_o;
  logic       width_err_o;
  logic       overflow_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] flips;
    logic [3:0] pulses;
    logic       sp;
    logic       ep;
    logic       werr;
    logic       ovf;
  } exp_t;

  typedef struct {
    logic [4:0] flips;
    logic [3:0] pulses;
    logic       sp;
    logic       ep;
    logic       werr;
    logic       ovf;
    logic       busy_mid;
    logic       busy_done;
    logic       got;
    int         lat;
    logic       done_after;
    logic [4:0] flip_after;
    logic [3:0] pulse_after;
  } obs_t;

  pulse_train_detector dut (
    .clk         (clk),
    .reset       (reset),
    .arm_i       (arm_i),
    .pulse_i     (pulse_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pulse_cnt_o (pulse_cnt_o),
    .flip_cnt_o  (flip_cnt_o),
    .start_pol_o (start_pol_o),
    .end_pol_o   (end_pol_o),
    .width_err_o (width_err_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle on the following falling edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Train-level reference: n edges, gaps between consecutive edges.
  function automatic exp_t model(input logic start, input int gaps[$]);
    exp_t e;
    int   n;
    n        = gaps.size() + 1;
    e.flips  = 5'((n > FMAX) ? FMAX : n);
    e.pulses = 4'(((n > FMAX) ? FMAX : n) / 2);
    e.sp     = start;
    e.ep     = start ^ ((n % 2) == 1);
    e.ovf    = (n > FMAX);
    e.werr   = 1'b0;
    foreach (gaps[i]) if (gaps[i] < LO || gaps[i] > HI) e.werr = 1'b1;
    return e;
  endfunction

  // Drive one armed train and snapshot the report at the done strobe.
  task automatic drive_train(input logic start, input int gaps[$], output obs_t o);
    logic lvl;
    int   cnt;
    arm_i = 1'b0; pulse_i = start; cyc(5);
    arm_i = 1'b1; cyc(2);
    lvl = ~start; pulse_i = lvl;
    foreach (gaps[i]) begin
      cyc(gaps[i]); lvl = ~lvl; pulse_i = lvl;
    end
    cyc(3); o.busy_mid = busy_o; cnt = 3;
    while (done_o !== 1'b1 && cnt < 60) begin cyc(1); cnt++; end
    o.got = (done_o === 1'b1); o.lat = cnt;
    o.flips = flip_cnt_o; o.pulses = pulse_cnt_o; o.sp = start_pol_o; o.ep = end_pol_o;
    o.werr = width_err_o; o.ovf = overflow_o; o.busy_done = busy_o;
    cyc(1);
    o.done_after = done_o; o.flip_after = flip_cnt_o; o.pulse_after = pulse_cnt_o;
  endtask

  task automatic test_reset();
    reset = 1'b1; arm_i = 1'b0; pulse_i = 1'b0; cyc(3);
    checks++; if ({busy_o, done_o, pulse_cnt_o, flip_cnt_o, start_pol_o, end_pol_o, width_err_o, overflow_o} !== 15'd0) begin
      errors++; $display("FAIL reset_outputs got %b exp 0", {busy_o, done_o, pulse_cnt_o, flip_cnt_o, start_pol_o, end_pol_o, width_err_o, overflow_o});
    end
    reset = 1'b0; cyc(2);
  endtask

  task automatic test_basic();
    int q[$] = '{3, 3, 3};
    obs_t o; exp_t e;
    e = model(1'b0, q); drive_train(1'b0, q, o);
    checks++; if (!o.got || o.lat != LAT) begin errors++; $display("FAIL basic_latency got %0d exp %0d", o.lat, LAT); end
    checks++; if (o.busy_mid !== 1'b1 || o.busy_done !== 1'b0) begin errors++; $display("FAIL basic_busy got %b%b exp 10", o.busy_mid, o.busy_done); end
    checks++; if (o.flips !== e.flips || o.pulses !== e.pulses) begin errors++; $display("FAIL basic_counts got %0d/%0d exp %0d/%0d", o.flips, o.pulses, e.flips, e.pulses); end
    checks++; if ({o.sp, o.ep, o.werr, o.ovf} !== {e.sp, e.ep, e.werr, e.ovf}) begin errors++; $display("FAIL basic_flags got %b exp %b", {o.sp, o.ep, o.werr, o.ovf}, {e.sp, e.ep, e.werr, e.ovf}); end
    checks++; if (o.done_after !== 1'b0) begin errors++; $display("FAIL basic_done_one_cycle got %b exp 0", o.done_after); end
    checks++; if (o.pulse_after !== e.pulses || o.flip_after !== 5'd0) begin errors++; $display("FAIL basic_hold got p%0d f%0d exp p%0d f0", o.pulse_after, o.flip_after, e.pulses); end
  endtask

  task automatic test_start_high();
    int q[$] = '{3, 3, 3, 3};
    obs_t o; exp_t e;
    e = model(1'b1, q); drive_train(1'b1, q, o);
    checks++; if (o.flips !== 5'd5 || o.pulses !== 4'd2) begin errors++; $display("FAIL high_counts got %0d/%0d exp 5/2", o.flips, o.pulses); end
    checks++; if ({o.sp, o.ep} !== 2'b10 || {o.sp, o.ep} !== {e.sp, e.ep}) begin errors++; $display("FAIL high_pol got %b exp 10", {o.sp, o.ep}); end
  endtask

  task automatic test_width_err();
    int q1[$] = '{3, 6, 3};
    int q2[$] = '{3, 3, 3};
    obs_t o;
    drive_train(1'b0, q1, o);
    checks++; if (o.werr !== 1'b1 || o.pulses !== 4'd2) begin errors++; $display("FAIL werr_set got %b/%0d exp 1/2", o.werr, o.pulses); end
    drive_train(1'b0, q2, o);
    checks++; if (o.werr !== 1'b0) begin errors++; $display("FAIL werr_clear got %b exp 0", o.werr); end
  endtask

  task automatic test_edge_wins();
    int q[$] = '{3, 12, 3};
    obs_t o; exp_t e;
    e = model(1'b0, q); drive_train(1'b0, q, o);
    checks++; if (!o.got || o.lat != LAT || o.flips !== e.flips || o.werr !== e.werr) begin
      errors++; $display("FAIL edge_wins got lat%0d f%0d w%b exp lat%0d f%0d w%b", o.lat, o.flips, o.werr, LAT, e.flips, e.werr);
    end
  endtask

  task automatic test_overflow();
    int q[$];
    obs_t o;
    for (int i = 0; i < 39; i++) q.push_back(3);
    drive_train(1'b0, q, o);
    checks++; if (o.flips !== 5'd31 || o.pulses !== 4'd15 || o.ovf !== 1'b1) begin
      errors++; $display("FAIL overflow got f%0d p%0d o%b exp f31 p15 o1", o.flips, o.pulses, o.ovf);
    end
  endtask

  task automatic test_random();
    obs_t o; exp_t e;
    for (int t = 0; t < 12; t++) begin
      int q[$];
      int n;
      logic st;
      st = 1'($urandom_range(0, 1));
      n  = int'($urandom_range(0, 11));
      for (int i = 0; i < n; i++) q.push_back(($urandom_range(0, 7) == 0) ? 12 : int'($urandom_range(1, 6)));
      e = model(st, q); drive_train(st, q, o);
      checks++; if (!o.got || o.lat != LAT) begin errors++; $display("FAIL rand%0d_latency got %0d exp %0d", t, o.lat, LAT); end
      checks++; if ({o.flips, o.pulses, o.sp, o.ep, o.werr, o.ovf} !== {e.flips, e.pulses, e.sp, e.ep, e.werr, e.ovf}) begin
        errors++; $display("FAIL rand%0d_report got f%0d p%0d %b%b%b%b exp f%0d p%0d %b%b%b%b", t,
          o.flips, o.pulses, o.sp, o.ep, o.werr, o.ovf, e.flips, e.pulses, e.sp, e.ep, e.werr, e.ovf);
      end
    end
  endtask

  task automatic test_abort();
    int q[$] = '{3};
    obs_t o;
    logic [3:0] prev_p;
    logic seen;
    arm_i = 1'b0; pulse_i = 1'b0; cyc(5);
    prev_p = pulse_cnt_o;
    arm_i = 1'b1; cyc(2);
    pulse_i = 1'b1; cyc(3); pulse_i = 1'b0; cyc(4);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b exp 1", busy_o); end
    arm_i = 1'b0; cyc(1);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy_after got %b exp 0", busy_o); end
    checks++; if (flip_cnt_o !== 5'd2 || pulse_cnt_o !== prev_p) begin errors++; $display("FAIL abort_partial got f%0d p%0d exp f2 p%0d", flip_cnt_o, pulse_cnt_o, prev_p); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin cyc(1); if (done_o === 1'b1) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL abort_no_done got 1 exp 0"); end
    drive_train(1'b0, q, o);
    checks++; if (!o.got || o.pulses !== 4'd1) begin errors++; $display("FAIL abort_rearm got %0d exp 1", o.pulses); end
  endtask

  task automatic test_async_reset();
    int q[$] = '{3, 3, 3, 3, 3};
    obs_t o;
    arm_i = 1'b0; pulse_i = 1'b0; cyc(5);
    arm_i = 1'b1; cyc(2);
    pulse_i = 1'b1; cyc(3); pulse_i = 1'b0; cyc(3); pulse_i = 1'b1; cyc(4);
    @(posedge clk); #2 reset = 1'b1; #1;
    checks++; if ({busy_o, done_o, pulse_cnt_o, flip_cnt_o, start_pol_o, end_pol_o, width_err_o, overflow_o} !== 15'd0) begin
      errors++; $display("FAIL async_reset got %b exp 0", {busy_o, done_o, pulse_cnt_o, flip_cnt_o, start_pol_o, end_pol_o, width_err_o, overflow_o});
    end
    cyc(2); reset = 1'b0; cyc(1);
    drive_train(1'b0, q, o);
    checks++; if (!o.got || o.pulses !== 4'd3) begin errors++; $display("FAIL async_reset_train got %0d exp 3", o.pulses); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_high();
    test_width_err();
    test_edge_wins();
    test_overflow();
    test_random();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
